// File: rtl/dcache_line_writer.sv
// dcache_line_writer: write-side front end of the data-cache line BRAM.
// Owns the single BRAM write port and feeds it from two sources:
//   - CPU store hits, written as a byte-enabled partial line write one cycle after acceptance.
//   - Memory refills, assembled beat by beat into a line buffer, then written as a full line.
// Every write-port output is registered so the BRAM sees clean, clock-aligned controls.
//
// Optional feature, enabled by defining DCACHE_STORE_MERGE_EN:
//   stores that hit the line being refilled are accepted during FILL and merged into the line
//   buffer; a per-byte merged mask keeps later refill beats from overwriting them, and the
//   merged bytes reach the BRAM as part of the commit write.

module dcache_line_writer #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BEAT_WIDTH = 64,
  localparam int unsigned BEATS      = DATA_WIDTH / BEAT_WIDTH,
  localparam int unsigned NBYTES     = DATA_WIDTH / 8,
  localparam int unsigned WORD_SEL_W = $clog2(DATA_WIDTH / 32)
) (
  input  logic                  clock,
  input  logic                  aclr_n,
  // Refill control
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_index,
  output logic                  fill_busy,
  output logic                  fill_done,
  // Refill beats
  input  logic                  mem_rvalid,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  output logic                  mem_rready,
  // Store requests
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_index,
  input  logic [WORD_SEL_W-1:0] st_word,
  input  logic [31:0]           st_data,
  input  logic [3:0]            st_be,
  // BRAM write port
  output logic [ADDR_WIDTH-1:0] bram_wraddress,
  output logic [DATA_WIDTH-1:0] bram_data,
  output logic [NBYTES-1:0]     bram_byteena,
  output logic                  bram_wren
);

  localparam int unsigned WORDS = DATA_WIDTH / 32;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StCommit
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] fidx_q;
  logic [DATA_WIDTH-1:0] line_q;
  logic [DATA_WIDTH-1:0] line_d;

  logic                  beat_fire;
  logic                  last_beat;
  logic                  st_fire;
  logic [NBYTES-1:0]     st_byte_mask;
  logic [DATA_WIDTH-1:0] st_line_data;
  logic [DATA_WIDTH-1:0] beat_line_data;
  logic [DATA_WIDTH-1:0] beat_bit_mask;
  logic [DATA_WIDTH-1:0] beat_wmask;

`ifdef DCACHE_STORE_MERGE_EN
  logic [NBYTES-1:0]     merged_q;
  logic [NBYTES-1:0]     merged_d;
  logic [DATA_WIDTH-1:0] merged_bits;
  logic [DATA_WIDTH-1:0] st_bit_mask;
  logic [DATA_WIDTH-1:0] st_wmask;
  logic                  merge_fire;
`endif

  // Status outputs come straight from the state register, so they are glitch-free.
  assign fill_busy  = (state_q == StFill) || (state_q == StCommit);
  assign fill_done  = (state_q == StCommit);
  assign mem_rready = (state_q == StFill);

  // Store acceptance; forced low while reset is asserted.
`ifdef DCACHE_STORE_MERGE_EN
  assign st_ready = aclr_n && ((state_q == StIdle) ||
                               ((state_q == StFill) && (st_index == fidx_q)));
`else
  assign st_ready = aclr_n && (state_q == StIdle);
`endif

  assign beat_fire = (state_q == StFill) && mem_rvalid;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign st_fire   = st_valid && st_ready;

  // Store bytes land in the 4-byte group of the selected word; data is replicated everywhere.
  assign st_byte_mask   = NBYTES'(st_be) << {st_word, 2'b00};
  assign st_line_data   = {WORDS{st_data}};
  assign beat_line_data = {BEATS{mem_rdata}};
  assign beat_bit_mask  = DATA_WIDTH'({BEAT_WIDTH{1'b1}}) << (BEAT_WIDTH * 32'(cnt_q));

`ifdef DCACHE_STORE_MERGE_EN
  assign merge_fire = st_fire && (state_q == StFill);

  // Expand per-byte masks to per-bit masks for the line buffer update.
  always_comb begin
    st_bit_mask = '0;
    merged_bits = '0;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      st_bit_mask[8*b +: 8] = {8{st_byte_mask[b]}};
      merged_bits[8*b +: 8] = {8{merged_q[b]}};
    end
  end

  // Merged mask: cleared when a refill starts, grows with every merged store.
  always_comb begin
    merged_d = merged_q;
    if ((state_q == StIdle) && fill_start) begin
      merged_d = '0;
    end else if (merge_fire) begin
      merged_d = merged_q | st_byte_mask;
    end
  end

  // Merged-byte mask register.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      merged_q <= '0;
    end else begin
      merged_q <= merged_d;
    end
  end
`endif

  // Next line buffer: beat into its slot, then (merge build) a same-cycle store wins over it.
  always_comb begin
    beat_wmask = beat_fire ? beat_bit_mask : '0;
`ifdef DCACHE_STORE_MERGE_EN
    beat_wmask = beat_wmask & ~merged_bits;
    st_wmask   = merge_fire ? st_bit_mask : '0;
`endif
    line_d = (line_q & ~beat_wmask) | (beat_line_data & beat_wmask);
`ifdef DCACHE_STORE_MERGE_EN
    line_d = (line_d & ~st_wmask) | (st_line_data & st_wmask);
`endif
  end

  // Control FSM with registered BRAM write-port outputs.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      fidx_q         <= '0;
      line_q         <= '0;
      bram_wren      <= 1'b0;
      bram_wraddress <= '0;
      bram_data      <= '0;
      bram_byteena   <= '0;
    end else begin
      bram_wren <= 1'b0;
      line_q    <= line_d;
      unique case (state_q)
        StIdle: begin
          // A store and a refill start may both be taken in the same cycle.
          if (st_fire) begin
            bram_wren      <= 1'b1;
            bram_wraddress <= st_index;
            bram_data      <= st_line_data;
            bram_byteena   <= st_byte_mask;
          end
          if (fill_start) begin
            state_q <= StFill;
            fidx_q  <= fill_index;
            cnt_q   <= '0;
          end
        end
        StFill: begin
          if (beat_fire) begin
            if (last_beat) begin
              // Commit uses line_d so the final beat goes out in the same write.
              state_q        <= StCommit;
              cnt_q          <= '0;
              bram_wren      <= 1'b1;
              bram_wraddress <= fidx_q;
              bram_data      <= line_d;
              bram_byteena   <= '1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StCommit: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
